// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV32M/RV64M multiply/divide unit with start/busy/done handshake and flush
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int BPC = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int N = WIDTH / BPC;
  localparam int CW = $clog2(N + 1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
  state_t state, next;
  logic [2:0] op_r;
  logic [WIDTH-1:0] a_r, b_r, m, a_mag, b_mag, q, res;
  logic [2*WIDTH-1:0] prod, step, pn;
  logic [WIDTH+BPC-1:0] sum;
  logic [WIDTH:0] r;
  logic [CW-1:0] cnt;
  logic sa, sb, dz, ovf, is_div, a_sgn, b_sgn;
  assign is_div = op_r[2];
  assign a_sgn = op_r == 3'd1 || op_r == 3'd2 || (op_r[2] && !op_r[0]);
  assign b_sgn = op_r == 3'd1 || (op_r[2] && !op_r[0]);
  assign a_mag = (a_sgn && a_r[WIDTH-1]) ? -a_r : a_r;
  assign b_mag = (b_sgn && b_r[WIDTH-1]) ? -b_r : b_r;
  assign busy = state != IDLE;
  assign done = state == DONE;
  // state register; reset lands in IDLE immediately
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  // sequencing; the counter-zero ITER cycle is idle so latency is N+3; flush wins everywhere
  always_comb begin
    next = state;
    case (state)
      IDLE: next = start ? PREP : IDLE;
      PREP: next = ITER;
      ITER: next = (cnt == '0) ? FIX : ITER;
      FIX: next = DONE;
      default: next = IDLE;
    endcase
    if (flush) next = IDLE;
  end
  // one iteration step: radix-2^BPC shift-add or BPC restoring-division bits; prod holds {rem, quotient}
  always_comb begin
    sum = {{BPC{1'b0}}, prod[2*WIDTH-1:WIDTH]} + {{BPC{1'b0}}, m} * {{WIDTH{1'b0}}, prod[BPC-1:0]};
    r = {1'b0, prod[2*WIDTH-1:WIDTH]};
    q = prod[WIDTH-1:0];
    for (int i = 0; i < BPC; i++) begin
      r = {r[WIDTH-1:0], q[WIDTH-1]};
      q = {q[WIDTH-2:0], 1'b0};
      if (r >= {1'b0, m}) begin
        r = r - {1'b0, m};
        q[0] = 1'b1;
      end
    end
    step = is_div ? {r[WIDTH-1:0], q} : {sum, prod[WIDTH-1:BPC]};
  end
  // sign correction, special cases and result select
  always_comb begin
    pn = (sa ^ sb) ? -prod : prod;
    res = !is_div ? (op_r == 3'd0 ? pn[WIDTH-1:0] : pn[2*WIDTH-1:WIDTH]) :
          op_r[1] ? (dz ? a_r : ovf ? '0 : sa ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH]) :
                    (dz ? '1 : ovf ? MIN : pn[WIDTH-1:0]);
  end
  // operand capture, preparation, iteration and result register
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      op_r <= '0;
      a_r <= '0;
      b_r <= '0;
      m <= '0;
      prod <= '0;
      cnt <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      dz <= 1'b0;
      ovf <= 1'b0;
      result <= '0;
    end else begin
      if (state == IDLE && start && !flush) begin
        op_r <= op;
        a_r <= a;
        b_r <= b;
      end
      if (state == PREP) begin
        sa <= a_sgn && a_r[WIDTH-1];
        sb <= b_sgn && b_r[WIDTH-1];
        dz <= b_r == '0;
        ovf <= is_div && !op_r[0] && a_r == MIN && &b_r;
        m <= is_div ? b_mag : a_mag;
        prod <= {{WIDTH{1'b0}}, is_div ? a_mag : b_mag};
        cnt <= CW'(N);
      end
      if (state == ITER && cnt != '0) begin
        prod <= step;
        cnt <= cnt - 1'b1;
      end
      if (state == FIX && !flush) result <= res;
    end
endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed and randomized checks of muldiv_iter against a behavioural model
module tb_muldiv_iter;
  localparam logic [31:0] MIN = 32'h8000_0000;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0;
  logic [2:0] op = '0;
  logic [31:0] a = '0, b = '0, result;
  logic busy, done;
  logic rst2 = 1'b1, start2 = 1'b0, busy2, done2;
  logic [63:0] a2 = '0, b2 = '0, result2;
  int checks = 0, errors = 0;
  int left = 0;
  logic [31:0] exp_res = '0, pend = '0;

  muldiv_iter #(.WIDTH(32), .BPC(1)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .result(result));
  muldiv_iter #(.WIDTH(64), .BPC(4)) dut2 (
    .clk(clk), .reset(rst2), .start(start2), .op(3'd0), .a(a2), .b(b2), .flush(1'b0),
    .busy(busy2), .done(done2), .result(result2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    case (o)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return '1;
        if (x == MIN && y == '1) return MIN;
        p = sx / sy; return p[31:0];
      end
      3'd5: return (y == 0) ? '1 : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == MIN && y == '1) return '0;
        p = sx % sy; return p[31:0];
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // model: an accepted start keeps the unit busy 36 cycles, done in the last, result visible from it
  always @(posedge clk) begin
    if (reset) begin
      left = 0;
      exp_res = '0;
    end else if (left > 0) begin
      left = flush ? 0 : left - 1;
      if (left == 1) exp_res = pend;
    end else if (start && !flush) begin
      left = 36;
      pend = model(op, a, b);
    end
  end

  always @(negedge clk) begin
    chk("busy", {63'b0, busy}, {63'b0, left > 0});
    chk("done", {63'b0, done}, {63'b0, left == 1});
    chk("result", {32'b0, result}, {32'b0, exp_res});
  end

  task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     output logic [31:0] r, output int lat);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    r = result;
  endtask

  logic [31:0] r;
  int lat, seen;
  initial begin
    #1;
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_done", {63'b0, done}, 64'd0);
    chk("reset_result", {32'b0, result}, 64'd0);
    @(posedge clk); #1 reset = 1'b0; rst2 = 1'b0;
    run(3'd3, '1, '1, r, lat); chk("mulhu", {32'b0, r}, 64'hFFFF_FFFE);
    chk("latency", lat, 35);
    run(3'd0, '1, '1, r, lat); chk("mul", {32'b0, r}, 64'h1);
    run(3'd2, '1, '1, r, lat); chk("mulhsu", {32'b0, r}, 64'hFFFF_FFFF);
    run(3'd1, MIN, MIN, r, lat); chk("mulh", {32'b0, r}, 64'h4000_0000);
    run(3'd4, 32'hFFFF_FFF9, 32'd2, r, lat); chk("div_neg", {32'b0, r}, 64'hFFFF_FFFD);
    run(3'd6, 32'hFFFF_FFF9, 32'd2, r, lat); chk("rem_neg", {32'b0, r}, 64'hFFFF_FFFF);
    run(3'd5, 32'd100, 32'd7, r, lat); chk("divu", {32'b0, r}, 64'd14);
    run(3'd7, 32'd100, 32'd7, r, lat); chk("remu", {32'b0, r}, 64'd2);
    run(3'd5, 32'd7, 32'd0, r, lat); chk("divu_zero", {32'b0, r}, 64'hFFFF_FFFF);
    run(3'd7, 32'd7, 32'd0, r, lat); chk("remu_zero", {32'b0, r}, 64'd7);
    chk("latency_special", lat, 35);
    run(3'd4, MIN, '1, r, lat); chk("div_ovf", {32'b0, r}, 64'h8000_0000);
    run(3'd6, MIN, '1, r, lat); chk("rem_ovf", {32'b0, r}, 64'd0);
    run(3'd7, 32'd100, 32'd7, r, lat);
    @(posedge clk); #1;
    start = 1'b1; op = 3'd4; a = 32'd100; b = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_busy", {63'b0, busy}, 64'd0);
    seen = 0;
    repeat (40) begin @(posedge clk); #1 if (done) seen++; end
    chk("flush_no_done", seen, 0);
    chk("flush_result", {32'b0, result}, 64'd2);
    @(posedge clk); #1;
    start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 start = 1'b1; op = 3'd0; a = 32'd50; b = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin @(posedge clk); #1 if (done) begin lat = k; break; end end
    chk("busy_start_done", {63'b0, lat > 0}, 64'd1);
    chk("busy_start_result", {32'b0, result}, 64'd14);
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      start = $urandom_range(0, 2) == 0;
      flush = $urandom_range(0, 60) == 0;
      op = 3'($urandom);
      case ($urandom_range(0, 5))
        0: a = '0; 1: a = MIN; 2: a = '1; default: a = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0: b = '0; 1: b = '1; 2: b = 32'($urandom_range(1, 9)); default: b = $urandom;
      endcase
    end
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    start2 = 1'b1; a2 = 64'd3; b2 = 64'd5;
    @(posedge clk); #1 start2 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin @(posedge clk); #1 if (done2) begin lat = k; break; end end
    chk("w64_latency", lat, 19);
    chk("w64_mul", result2, 64'd15);
    @(posedge clk); #1;
    start2 = 1'b1; a2 = 64'd7; b2 = 64'd9;
    @(posedge clk); #1 start2 = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst2 = 1'b1;
    #1;
    chk("w64_reset_busy", {63'b0, busy2}, 64'd0);
    chk("w64_reset_result", result2, 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
